// File: rtl/mips_multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl_if
//   Memory handshake bundle between the multi-cycle controller and the
//   instruction/data memories.
//
//   Handshake: a request (imem_req / dmem_req) is held high continuously
//   until the matching ready is sampled high on a rising clock edge, or
//   until the controller gives up and traps. A transfer completes on the
//   edge where req and ready are both high. dmem_we qualifies dmem_req
//   (1 = write) and is meaningful only while dmem_req is high.
//
//   Signals
//     imem_req   controller -> imem   fetch request
//     imem_ready imem -> controller   instruction word valid this cycle
//     dmem_req   controller -> dmem   data access request
//     dmem_we    controller -> dmem   data access is a write
//     dmem_ready dmem -> controller   data access completes this cycle
// ---------------------------------------------------------------------------
interface mips_multicycle_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Multi-cycle MIPS control FSM (R-type, lw, sw, beq). Sequences one
//   instruction at a time, drives every datapath enable and mux select,
//   handshakes with both memories, traps on illegal opcodes and memory
//   timeouts, and counts retired instructions.
//
//   Ports
//     clk, rst      clock (rising edge), asynchronous active-low reset
//     run           1 = execute, 0 = stop at the next instruction boundary
//     opcode, zero  Inst[31:26] and the ALU zero flag
//     mem           memory handshake bundle (master side)
//     ir_we .. alu_op  datapath enables and selects
//     halt, cause   trap indication and its reason
//     retired       retired-instruction count (wraps)
//     dbg_state     current FSM state encoding
//
//   Outputs are decoded from the registered state; ir_we/pc_we in FETCH are
//   additionally qualified by imem_ready, and pc_we in EXEC_BR by zero.
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [5:0]           opcode,
    input  logic                 zero,
    mips_multicycle_ctrl_if.master mem,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 pc_src,
    output logic                 rf_we,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 alu_src,
    output logic [1:0]           alu_op,
    output logic                 halt,
    output logic [1:0]           cause,
    output logic [CNT_W-1:0]     retired,
    output logic [3:0]           dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC_R    = 4'd3,
        S_EXEC_ADDR = 4'd4,
        S_EXEC_BR   = 4'd5,
        S_MEM       = 4'd6,
        S_WB_R      = 4'd7,
        S_WB_LD     = 4'd8,
        S_TRAP      = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    // Value of the wait counter during the TIMEOUT-th consecutive
    // not-ready cycle; a not-ready cycle seen at this count traps.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t             state_q,   state_d;
    logic [WAIT_W-1:0]  wait_q,    wait_d;
    logic               is_sw_q,   is_sw_d;
    logic [1:0]         cause_q,   cause_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    logic imem_req;
    logic dmem_req;
    logic dmem_we;
    logic retire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            is_sw_q   <= 1'b0;
            cause_q   <= 2'b00;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            is_sw_q   <= is_sw_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        // The wait counter is zero in every state except while a memory
        // wait is in progress, so entering FETCH or MEM always starts at 0.
        wait_d     = '0;
        is_sw_d    = is_sw_q;
        cause_d    = cause_q;
        retired_d  = retired_q;
        retire     = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        rf_we      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        halt       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end

            S_FETCH: begin
                imem_req = 1'b1;
                // Ready is tested before the timeout so a ready arriving on
                // the last allowed cycle still completes the fetch.
                if (mem.imem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    cause_d = CAUSE_IMEM_TO;
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_DECODE: begin
                is_sw_d = (opcode == OP_SW);
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_EXEC_ADDR;
                    OP_BEQ:       state_d = S_EXEC_BR;
                    default: begin
                        cause_d = CAUSE_ILLEGAL;
                        state_d = S_TRAP;
                    end
                endcase
            end

            S_EXEC_R: begin
                alu_op  = 2'b10;
                state_d = S_WB_R;
            end

            S_WB_R: begin
                rf_we   = 1'b1;
                reg_dst = 1'b1;
                retire  = 1'b1;
            end

            S_EXEC_ADDR: begin
                alu_src = 1'b1;
                state_d = S_MEM;
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw_q;
                if (mem.dmem_ready) begin
                    if (is_sw_q) retire = 1'b1;
                    else         state_d = S_WB_LD;
                end else if (wait_q == WAIT_LAST) begin
                    cause_d = CAUSE_DMEM_TO;
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_WB_LD: begin
                rf_we      = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end

            S_EXEC_BR: begin
                alu_op = 2'b01;
                pc_src = 1'b1;
                pc_we  = zero;
                retire = 1'b1;
            end

            S_TRAP: begin
                halt = 1'b1;
            end

            default: state_d = S_IDLE;
        endcase

        // run is only honoured at an instruction boundary.
        if (retire) begin
            retired_d = retired_q + 1'b1;
            state_d   = run ? S_FETCH : S_IDLE;
        end
    end

    assign mem.imem_req = imem_req;
    assign mem.dmem_req = dmem_req;
    assign mem.dmem_we  = dmem_we;
    assign cause        = cause_q;
    assign retired      = retired_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//   Directed bench for mips_multicycle_ctrl (CNT_W=32, TIMEOUT=16).
//   Inputs change 1 time unit after a rising edge; outputs are sampled
//   there too, clear of the active edge.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_EXEC_R    = 4'd3;
    localparam logic [3:0] S_EXEC_ADDR = 4'd4;
    localparam logic [3:0] S_EXEC_BR   = 4'd5;
    localparam logic [3:0] S_MEM       = 4'd6;
    localparam logic [3:0] S_WB_R      = 4'd7;
    localparam logic [3:0] S_WB_LD     = 4'd8;
    localparam logic [3:0] S_TRAP      = 4'd9;

    logic        clk;
    logic        rst;
    logic        run;
    logic [5:0]  opcode;
    logic        zero;
    logic        ir_we, pc_we, pc_src, rf_we, reg_dst, mem_to_reg, alu_src;
    logic [1:0]  alu_op;
    logic        halt;
    logic [1:0]  cause;
    logic [31:0] retired;
    logic [3:0]  dbg_state;

    int cmp_cnt = 0;
    int err_cnt = 0;

    mips_multicycle_ctrl_if mem_if ();

    mips_multicycle_ctrl #(.CNT_W(32), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .zero       (zero),
        .mem        (mem_if.master),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .rf_we      (rf_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .halt       (halt),
        .cause      (cause),
        .retired    (retired),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All enables/selects/requests packed; zero means fully quiet.
    function automatic logic [12:0] outs();
        return {mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_we, ir_we, pc_we,
                pc_src, rf_we, reg_dst, mem_to_reg, alu_src, alu_op, halt};
    endfunction

    // Reset, release with run=0, one IDLE edge, then run=1 into FETCH.
    task automatic reset_to_fetch();
        rst = 1'b0;
        run = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rel_idle", dbg_state, S_IDLE);
        run = 1'b1;
        tick();
        chk("rel_fetch", dbg_state, S_FETCH);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        run = 1'b0;
        opcode = 6'b000000;
        zero = 1'b0;
        mem_if.imem_ready = 1'b0;
        mem_if.dmem_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_state",   dbg_state, S_IDLE);
        chk("rst_retired", retired, 0);
        chk("rst_cause",   cause, 2'b00);
        chk("rst_outs",    outs(), 13'h0);
        tick();
        rst = 1'b1;
        mem_if.imem_ready = 1'b1;
        mem_if.dmem_ready = 1'b1;
        tick();
        chk("idle_hold", dbg_state, S_IDLE);
        chk("idle_outs", outs(), 13'h0);
        run = 1'b1;
        tick();
        chk("fetch_state",   dbg_state, S_FETCH);
        chk("fetch_imemreq", mem_if.imem_req, 1'b1);
        chk("fetch_ir_we",   ir_we, 1'b1);
        chk("fetch_pc_we",   pc_we, 1'b1);
        chk("fetch_pc_src",  pc_src, 1'b0);

        // R-type x10, 4 cycles each
        for (int i = 0; i < 10; i++) begin
            chk("r_fetch", dbg_state, S_FETCH);
            tick();
            chk("r_decode", dbg_state, S_DECODE);
            chk("r_dec_rfwe", rf_we, 1'b0);
            tick();
            chk("r_exec", dbg_state, S_EXEC_R);
            chk("r_exec_aluop", alu_op, 2'b10);
            chk("r_exec_rfwe", rf_we, 1'b0);
            tick();
            chk("r_wb", dbg_state, S_WB_R);
            chk("r_wb_rfwe", rf_we, 1'b1);
            chk("r_wb_regdst", reg_dst, 1'b1);
            chk("r_wb_m2r", mem_to_reg, 1'b0);
            chk("r_wb_retired", retired, i);
            tick();
            chk("r_retired", retired, i + 1);
        end
        chk("r10_fetch", dbg_state, S_FETCH);

        // lw with 3 wait cycles: 8 cycles
        opcode = 6'b100011;
        mem_if.dmem_ready = 1'b0;
        tick();
        chk("lw_decode", dbg_state, S_DECODE);
        tick();
        chk("lw_exaddr", dbg_state, S_EXEC_ADDR);
        chk("lw_alusrc", alu_src, 1'b1);
        chk("lw_aluop", alu_op, 2'b00);
        tick();
        for (int k = 0; k < 4; k++) begin
            mem_if.dmem_ready = (k == 3);
            #1;
            chk("lw_mem", dbg_state, S_MEM);
            chk("lw_dmemreq", mem_if.dmem_req, 1'b1);
            chk("lw_dmemwe", mem_if.dmem_we, 1'b0);
            tick();
        end
        chk("lw_wb", dbg_state, S_WB_LD);
        chk("lw_wb_rfwe", rf_we, 1'b1);
        chk("lw_wb_regdst", reg_dst, 1'b0);
        chk("lw_wb_m2r", mem_to_reg, 1'b1);
        chk("lw_wb_dmemreq", mem_if.dmem_req, 1'b0);
        mem_if.dmem_ready = 1'b0;
        opcode = 6'b101011;
        tick();
        chk("lw_retire_state", dbg_state, S_FETCH);
        chk("lw_retired", retired, 11);

        // sw with 3 wait cycles: 7 cycles
        tick();
        chk("sw_decode", dbg_state, S_DECODE);
        tick();
        chk("sw_exaddr", dbg_state, S_EXEC_ADDR);
        tick();
        for (int k = 0; k < 4; k++) begin
            mem_if.dmem_ready = (k == 3);
            #1;
            chk("sw_mem", dbg_state, S_MEM);
            chk("sw_dmemreq", mem_if.dmem_req, 1'b1);
            chk("sw_dmemwe", mem_if.dmem_we, 1'b1);
            chk("sw_rfwe", rf_we, 1'b0);
            chk("sw_retired_hold", retired, 11);
            tick();
        end
        chk("sw_retire_state", dbg_state, S_FETCH);
        chk("sw_retired", retired, 12);
        mem_if.dmem_ready = 1'b1;

        // beq taken then not taken: 3 cycles each
        opcode = 6'b000100;
        zero = 1'b1;
        tick();
        chk("beq1_decode", dbg_state, S_DECODE);
        tick();
        chk("beq1_exec", dbg_state, S_EXEC_BR);
        chk("beq1_pcwe", pc_we, 1'b1);
        chk("beq1_pcsrc", pc_src, 1'b1);
        chk("beq1_aluop", alu_op, 2'b01);
        chk("beq1_alusrc", alu_src, 1'b0);
        tick();
        chk("beq1_fetch", dbg_state, S_FETCH);
        chk("beq1_retired", retired, 13);
        zero = 1'b0;
        tick();
        chk("beq0_decode", dbg_state, S_DECODE);
        tick();
        chk("beq0_exec", dbg_state, S_EXEC_BR);
        chk("beq0_pcwe", pc_we, 1'b0);
        tick();
        chk("beq0_fetch", dbg_state, S_FETCH);
        chk("beq0_retired", retired, 14);

        // run dropped during EXEC_R: instruction completes, then IDLE
        opcode = 6'b000000;
        tick();
        tick();
        chk("rundrop_exec", dbg_state, S_EXEC_R);
        run = 1'b0;
        tick();
        chk("rundrop_wb", dbg_state, S_WB_R);
        tick();
        chk("rundrop_idle", dbg_state, S_IDLE);
        chk("rundrop_retired", retired, 15);
        tick();
        chk("rundrop_stay", dbg_state, S_IDLE);
        chk("rundrop_outs", outs(), 13'h0);

        // Fetch with ready on the 16th cycle: normal fetch
        mem_if.imem_ready = 1'b0;
        run = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            mem_if.imem_ready = (k == 15);
            #1;
            chk("late_fetch", dbg_state, S_FETCH);
            chk("late_imemreq", mem_if.imem_req, 1'b1);
            chk("late_irwe", ir_we, (k == 15));
            tick();
        end
        chk("late_decode", dbg_state, S_DECODE);
        chk("late_cause", cause, 2'b00);
        mem_if.imem_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("late_retire", dbg_state, S_FETCH);
        chk("late_retired", retired, 16);

        // Reset pulsed mid-MEM
        opcode = 6'b100011;
        mem_if.dmem_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("midmem_state", dbg_state, S_MEM);
        #2;
        rst = 1'b0;
        #1;
        chk("midmem_rst_state", dbg_state, S_IDLE);
        chk("midmem_rst_retired", retired, 0);
        chk("midmem_rst_outs", outs(), 13'h0);
        chk("midmem_rst_cause", cause, 2'b00);

        // dmem timeout: 16 MEM cycles then TRAP cause=11
        opcode = 6'b101011;
        reset_to_fetch();
        tick();
        tick();
        tick();
        for (int k = 0; k < 16; k++) begin
            chk("dto_mem", dbg_state, S_MEM);
            chk("dto_dmemreq", mem_if.dmem_req, 1'b1);
            tick();
        end
        chk("dto_trap", dbg_state, S_TRAP);
        chk("dto_cause", cause, 2'b11);
        chk("dto_halt", halt, 1'b1);
        chk("dto_retired", retired, 0);
        chk("dto_dmemreq_off", mem_if.dmem_req, 1'b0);

        // imem timeout: 16 FETCH cycles then TRAP cause=10
        mem_if.imem_ready = 1'b0;
        opcode = 6'b000000;
        reset_to_fetch();
        for (int k = 0; k < 16; k++) begin
            chk("ito_fetch", dbg_state, S_FETCH);
            chk("ito_irwe", ir_we, 1'b0);
            tick();
        end
        chk("ito_trap", dbg_state, S_TRAP);
        chk("ito_cause", cause, 2'b10);
        chk("ito_halt", halt, 1'b1);
        chk("ito_imemreq", mem_if.imem_req, 1'b0);

        // Illegal opcode: TRAP after DECODE, held until reset
        mem_if.imem_ready = 1'b1;
        mem_if.dmem_ready = 1'b1;
        opcode = 6'b111111;
        reset_to_fetch();
        tick();
        chk("ill_decode", dbg_state, S_DECODE);
        tick();
        chk("ill_trap", dbg_state, S_TRAP);
        chk("ill_cause", cause, 2'b01);
        chk("ill_halt", halt, 1'b1);
        zero = 1'b1;
        opcode = 6'b000000;
        for (int k = 0; k < 5; k++) begin
            run = k[0];
            tick();
            chk("ill_hold", dbg_state, S_TRAP);
            chk("ill_quiet", outs(), 13'h1);
            chk("ill_cause_hold", cause, 2'b01);
        end
        rst = 1'b0;
        #1;
        chk("ill_rst_state", dbg_state, S_IDLE);
        chk("ill_rst_halt", halt, 1'b0);
        chk("ill_rst_cause", cause, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control FSM that sequences the MIPS datapath (PC, instruction memory, register file, ALU control/ALU, data memory) one instruction at a time. It supports R-type, lw, sw and beq. It produces every datapath enable and mux select, and handshakes with both memories. It traps on illegal opcodes and memory timeouts, and counts retired instructions.

## Interface
- CNT_W, 32, width of retired-instruction counter
- TIMEOUT, 16, max cycles waiting for a memory ready before trap (≥1)
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- run  input  1  1 = execute; 0 = stop at next instruction boundary
- opcode  input  6  Inst[31:26] from the instruction register
- zero  input  1  ALU zero flag
- imem_ready  input  1  instruction word valid this cycle
- dmem_ready  input  1  data memory access completes this cycle
- imem_req  output  1  fetch request
- ir_we  output  1  load instruction register
- pc_we  output  1  load PC
- pc_src  output  1  0 = PC+1, 1 = branch target
- rf_we  output  1  register file write
- reg_dst  output  1  1 = rd (Inst[15:11]), 0 = rt
- mem_to_reg  output  1  1 = write-back from data memory, 0 = from ALU
- alu_src  output  1  1 = sign-extended immediate, 0 = rt data
- alu_op  output  2  00 add, 01 subtract, 10 use funct
- dmem_req  output  1  data memory request
- dmem_we  output  1  data memory write (valid with dmem_req)
- halt  output  1  controller is in TRAP
- cause  output  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
- retired  output  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_ADDR, EXEC_BR, MEM, WB_R, WB_LD, TRAP.
- Outputs are Moore (decoded from the registered state), except where noted as qualified by a ready input. Any output not listed for a state is 0.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH: imem_req=1.
  - With imem_ready=1: ir_we=1, pc_we=1, pc_src=0, go to DECODE.
  - Otherwise stay.
- DECODE: latch the instruction class from opcode.
  - 000000 goes to EXEC_R.
  - 100011 (lw) and 101011 (sw) go to EXEC_ADDR.
  - 000100 (beq) goes to EXEC_BR.
  - Any other opcode goes to TRAP with cause=01.
- EXEC_R: alu_src=0, alu_op=10; go to WB_R.
- WB_R: rf_we=1, reg_dst=1, mem_to_reg=0; retire.
- EXEC_ADDR: alu_src=1, alu_op=00; go to MEM.
- MEM: dmem_req=1, dmem_we=1 if the latched class is sw.
  - On dmem_ready for sw: retire.
  - On dmem_ready for lw: go to WB_LD.
- WB_LD: rf_we=1, reg_dst=0, mem_to_reg=1; retire.
- EXEC_BR: alu_src=0, alu_op=01, pc_src=1, pc_we=zero; retire.
- Retire means: retired increments by 1 (wraps modulo 2^CNT_W), then go to FETCH if run=1, else IDLE.
- TRAP: halt=1, cause holds its value. The only exit is reset.
- Timeout:
  - A wait counter clears on entry to FETCH or MEM.
  - It increments each cycle the ready input is low.
  - When TIMEOUT consecutive not-ready cycles have elapsed, go to TRAP with cause=10 (FETCH) or 11 (MEM). No enables are issued.
  - A ready arriving on the same cycle the count hits TIMEOUT wins; the transfer completes normally.
- run=0 takes effect only in IDLE or at retire. An instruction in flight always completes.

## Timing
- Reset (asynchronous, rst=0): state=IDLE, retired=0, cause=00, halt=0, all enables/selects 0, wait counter 0.
- Reset release: IDLE on the first edge. With run=1, FETCH on the next edge.
- Minimum cycles per instruction, with ready asserted on the first request cycle:

  | Instruction | States | Cycles |
  |---|---|---|
  | R-type | FETCH, DECODE, EXEC_R, WB_R | 4 |
  | lw | FETCH, DECODE, EXEC_ADDR, MEM, WB_LD | 5 |
  | sw | FETCH, DECODE, EXEC_ADDR, MEM | 4 |
  | beq | FETCH, DECODE, EXEC_BR | 3 |

  Each ready wait cycle adds one cycle.
- retired updates on the edge that leaves the final state of the instruction.
- imem_req and dmem_req stay asserted continuously until ready or timeout.
- Reset mid-instruction: the instruction is abandoned with no retire, and rst overrides all other inputs.

## Test plan
- Reset, then run=1, both readies tied 1, R-type opcode 000000. Expect:
  - the FETCH, DECODE, EXEC_R, WB_R sequence;
  - rf_we=1 with reg_dst=1 only in WB_R;
  - retired=1 after 4 cycles and 10 after 40 cycles.
- lw then sw, dmem_ready delayed 3 cycles. Expect:
  - dmem_req held 4 cycles each, dmem_we=1 only for sw;
  - lw takes 8 cycles, sw 7, retired=2.
- beq with zero=1, then beq with zero=0. Expect:
  - pc_we=1 and pc_src=1 in EXEC_BR only for the first;
  - 3 cycles each.
- Opcode 111111. Expect:
  - TRAP on the cycle after DECODE, halt=1, cause=01;
  - no rf_we, pc_we or dmem_req afterwards;
  - state held until rst=0.
- Timeouts, with TIMEOUT=16:
  - imem_ready held 0 gives TRAP with cause=10 after 16 FETCH cycles;
  - a repeat with ready on cycle 16 gives a normal fetch;
  - dmem_ready held 0 gives cause=11.
- Run and reset control:
  - run dropped during EXEC_R: the instruction retires, then the FSM goes to IDLE;
  - rst pulsed low mid-MEM: immediate IDLE, retired=0, all outputs 0.
